// File: rtl/product_accumulator_pkg.sv
// Shared types and default widths for the product accumulator.
package product_accumulator_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_e;

    localparam int IN_W_DEF  = 18;
    localparam int ACC_W_DEF = 32;
    localparam int LEN_DEF   = 8;

endpackage

// File: rtl/product_accumulator_if.sv
// Product input stream, clear strobe and frame-result output stream.
// The slave modport is the accumulator's view; master is its driver/consumer.
interface product_accumulator_if #(
    parameter int IN_W  = 18,
    parameter int ACC_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_prod;
    logic             clear;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic             out_ovf;

    modport slave (
        input  in_valid, in_prod, clear, out_ready,
        output in_ready, out_valid, out_sum, out_ovf
    );

    modport master (
        output in_valid, in_prod, clear, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf
    );
endinterface

// File: rtl/product_accumulator_sat_adder.sv
// W-bit adder; with PRODUCT_ACCUMULATOR_SATURATE_EN it clamps to all-ones on
// carry-out and flags it on sat_o, otherwise it wraps and has no carry port.
module product_accumulator_sat_adder #(
    parameter int W = 32
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    output logic         sat_o,
`endif
    output logic [W-1:0] sum_o
);

`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    logic [W-1:0] raw_sum;
    logic         carry;

    assign {carry, raw_sum} = {1'b0, a_i} + {1'b0, b_i};
    assign sat_o            = carry;
    assign sum_o            = carry ? {W{1'b1}} : raw_sum;
`else
    assign sum_o = a_i + b_i;
`endif

endmodule

// File: rtl/product_accumulator.sv
// Sums LEN accepted products into one frame result (PRODUCT_ACCUMULATOR_SATURATE_EN: saturating add + out_ovf).
// Latency: out_valid rises 1 cycle after the LEN-th beat is accepted.
// Backpressure: in_ready is low while a result is held or clear is high; result held until out_ready.
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int LEN   = LEN_DEF
) (
    input logic                   clk,
    input logic                   rst_n,
    product_accumulator_if.slave  bus
);

    localparam int               CNT_W    = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

    acc_state_e       state_q;
    logic [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             out_valid_q;
    logic [ACC_W-1:0] out_sum_q;

    logic [ACC_W-1:0] prod_d;
    logic [ACC_W-1:0] sum_d;
    logic             in_ready_d;
    logic             beat_d;
    logic             xfer_d;

    // clear gates in_ready so a beat offered alongside an abort is never taken
    assign in_ready_d = (state_q == ACCUM) && !bus.clear;
    assign beat_d     = bus.in_valid && in_ready_d;
    assign xfer_d     = out_valid_q && bus.out_ready;
    assign prod_d     = ACC_W'(bus.in_prod);

`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    logic sat_d;
    logic ovf_q;
    logic out_ovf_q;

    product_accumulator_sat_adder #(.W(ACC_W)) u_add (
        .a_i   (acc_q),
        .b_i   (prod_d),
        .sat_o (sat_d),
        .sum_o (sum_d)
    );
`else
    product_accumulator_sat_adder #(.W(ACC_W)) u_add (
        .a_i   (acc_q),
        .b_i   (prod_d),
        .sum_o (sum_d)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
            ovf_q       <= 1'b0;
            out_ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                ACCUM: begin
                    if (bus.clear) begin
                        acc_q <= '0;
                        cnt_q <= '0;
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
                        ovf_q <= 1'b0;
`endif
                    end else if (beat_d) begin
                        if (cnt_q == CNT_LAST) begin
                            out_sum_q   <= sum_d;
                            out_valid_q <= 1'b1;
                            acc_q       <= '0;
                            cnt_q       <= '0;
                            state_q     <= HOLD;
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
                            out_ovf_q   <= ovf_q | sat_d;
                            ovf_q       <= 1'b0;
`endif
                        end else begin
                            acc_q <= sum_d;
                            cnt_q <= cnt_q + CNT_W'(1);
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
                            ovf_q <= ovf_q | sat_d;
`endif
                        end
                    end
                end
                // clear is deliberately ignored here: a finished result is never dropped
                HOLD: begin
                    if (xfer_d) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ACCUM;
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_d;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    assign bus.out_ovf   = out_ovf_q;
`else
    assign bus.out_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_product_accumulator.sv
// Testbench for product_accumulator: directed scenarios on LEN=8/ACC_W=32,
// ACC_W=20 and LEN=1 instances, then a randomized run against a frame-level model.
module tb_product_accumulator;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    product_accumulator_if #(.IN_W(18), .ACC_W(32)) bus0 ();
    product_accumulator_if #(.IN_W(18), .ACC_W(20)) bus_o ();
    product_accumulator_if #(.IN_W(18), .ACC_W(32)) bus_1 ();

    product_accumulator #(.IN_W(18), .ACC_W(32), .LEN(8)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus0));
    product_accumulator #(.IN_W(18), .ACC_W(20), .LEN(8)) dut_o (
        .clk(clk), .rst_n(rst_n), .bus(bus_o));
    product_accumulator #(.IN_W(18), .ACC_W(32), .LEN(1)) dut_1 (
        .clk(clk), .rst_n(rst_n), .bus(bus_1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected frame result from the exact (unbounded) sum of the frame's products.
    // All products are non-negative, so clamping each add equals clamping the total.
    function automatic void frame_result(input longint unsigned tot, input int w,
                                         output logic [31:0] s, output logic o);
        longint unsigned maxv;
        maxv = (64'd1 << w) - 64'd1;
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
        if (tot > maxv) begin s = 32'(maxv); o = 1'b1; end
        else            begin s = 32'(tot);  o = 1'b0; end
`else
        s = 32'(tot & maxv);
        o = 1'b0;
`endif
    endfunction

    // Stimulus only: n back-to-back beats of one value into the LEN=8/ACC_W=32 instance.
    task automatic beats(input int n, input int unsigned prod, input logic ordy);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus0.in_valid  = 1'b1;
            bus0.in_prod   = 18'(prod);
            bus0.clear     = 1'b0;
            bus0.out_ready = ordy;
        end
    endtask

    task automatic test_reset();
        #1;
        vectors++; if (bus0.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", bus0.out_valid); end
        vectors++; if (bus0.out_sum !== 32'd0) begin miscompares++; $display("FAIL reset_out_sum: got %0d want 0", bus0.out_sum); end
        vectors++; if (bus0.out_ovf !== 1'b0) begin miscompares++; $display("FAIL reset_out_ovf: got %b want 0", bus0.out_ovf); end
        vectors++; if (bus_1.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_len1_out_valid: got %b want 0", bus_1.out_valid); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++; if (bus0.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", bus0.in_ready); end
    endtask

    task automatic test_basic();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus0.in_valid = 1'b1; bus0.in_prod = 18'd4; bus0.out_ready = 1'b1;
            #1;
            vectors++; if (bus0.in_ready !== 1'b1) begin miscompares++; $display("FAIL basic_in_ready_beat%0d: got %b want 1", i, bus0.in_ready); end
            vectors++; if (bus0.out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_early_valid_beat%0d: got %b want 0", i, bus0.out_valid); end
        end
        @(negedge clk);
        bus0.in_valid = 1'b0;
        #1;
        vectors++; if (bus0.out_valid !== 1'b1) begin miscompares++; $display("FAIL basic_out_valid: got %b want 1", bus0.out_valid); end
        vectors++; if (bus0.out_sum !== 32'd32) begin miscompares++; $display("FAIL basic_out_sum: got %0d want 32", bus0.out_sum); end
        vectors++; if (bus0.out_ovf !== 1'b0) begin miscompares++; $display("FAIL basic_out_ovf: got %b want 0", bus0.out_ovf); end
        vectors++; if (bus0.in_ready !== 1'b0) begin miscompares++; $display("FAIL basic_hold_in_ready: got %b want 0", bus0.in_ready); end
        @(negedge clk);
        #1;
        vectors++; if (bus0.out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_after_xfer_valid: got %b want 0", bus0.out_valid); end
        vectors++; if (bus0.in_ready !== 1'b1) begin miscompares++; $display("FAIL basic_after_xfer_in_ready: got %b want 1", bus0.in_ready); end
    endtask

    task automatic test_backpressure();
        beats(8, 4, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus0.in_valid = 1'b1; bus0.in_prod = 18'd9; bus0.out_ready = 1'b0;
            #1;
            vectors++; if (bus0.out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid_c%0d: got %b want 1", i, bus0.out_valid); end
            vectors++; if (bus0.out_sum !== 32'd32) begin miscompares++; $display("FAIL bp_sum_c%0d: got %0d want 32", i, bus0.out_sum); end
            vectors++; if (bus0.in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready_c%0d: got %b want 0", i, bus0.in_ready); end
        end
        @(negedge clk);
        bus0.out_ready = 1'b1;
        #1;
        vectors++; if (bus0.in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_xfer_cycle_in_ready: got %b want 0", bus0.in_ready); end
        @(negedge clk);
        #1;
        vectors++; if (bus0.out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_post_xfer_valid: got %b want 0", bus0.out_valid); end
        vectors++; if (bus0.in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_post_xfer_in_ready: got %b want 1", bus0.in_ready); end
        @(negedge clk);
        bus0.in_valid = 1'b0; bus0.clear = 1'b1;
        @(negedge clk);
        bus0.clear = 1'b0;
    endtask

    task automatic test_clear();
        beats(3, 10, 1'b0);
        @(negedge clk);
        bus0.in_valid = 1'b1; bus0.in_prod = 18'd7; bus0.clear = 1'b1;
        #1;
        vectors++; if (bus0.in_ready !== 1'b0) begin miscompares++; $display("FAIL clear_in_ready: got %b want 0", bus0.in_ready); end
        beats(8, 1, 1'b0);
        @(negedge clk);
        bus0.in_valid = 1'b0;
        #1;
        vectors++; if (bus0.out_valid !== 1'b1) begin miscompares++; $display("FAIL clear_valid: got %b want 1", bus0.out_valid); end
        vectors++; if (bus0.out_sum !== 32'd8) begin miscompares++; $display("FAIL clear_sum: got %0d want 8", bus0.out_sum); end
        bus0.clear = 1'b1;
        @(negedge clk);
        #1;
        vectors++; if (bus0.out_valid !== 1'b1) begin miscompares++; $display("FAIL clear_hold_valid: got %b want 1", bus0.out_valid); end
        vectors++; if (bus0.out_sum !== 32'd8) begin miscompares++; $display("FAIL clear_hold_sum: got %0d want 8", bus0.out_sum); end
        bus0.clear = 1'b0; bus0.out_ready = 1'b1;
        @(negedge clk);
        #1;
        vectors++; if (bus0.out_valid !== 1'b0) begin miscompares++; $display("FAIL clear_xfer_valid: got %b want 0", bus0.out_valid); end
    endtask

    task automatic test_async_reset();
        beats(5, 2, 1'b1);
        @(negedge clk);
        bus0.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (bus0.out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mid_valid: got %b want 0", bus0.out_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        beats(8, 5, 1'b0);
        @(negedge clk);
        bus0.in_valid = 1'b0;
        #1;
        vectors++; if (bus0.out_sum !== 32'd40) begin miscompares++; $display("FAIL rst_pre_hold_sum: got %0d want 40", bus0.out_sum); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (bus0.out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_hold_valid: got %b want 0", bus0.out_valid); end
        vectors++; if (bus0.out_sum !== 32'd0) begin miscompares++; $display("FAIL rst_hold_sum: got %0d want 0", bus0.out_sum); end
        @(negedge clk);
        rst_n = 1'b1;
        beats(8, 2, 1'b1);
        @(negedge clk);
        bus0.in_valid = 1'b0;
        #1;
        vectors++; if (bus0.out_valid !== 1'b1) begin miscompares++; $display("FAIL rst_fresh_valid: got %b want 1", bus0.out_valid); end
        vectors++; if (bus0.out_sum !== 32'd16) begin miscompares++; $display("FAIL rst_fresh_sum: got %0d want 16", bus0.out_sum); end
        @(negedge clk);
    endtask

    task automatic test_overflow();
        logic [19:0] exp_big;
        logic        exp_big_ovf;
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
        exp_big = 20'd1048575; exp_big_ovf = 1'b1;
`else
        exp_big = 20'd1040392; exp_big_ovf = 1'b0;
`endif
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                bus_o.in_valid = 1'b1; bus_o.out_ready = 1'b1;
                bus_o.in_prod = (f == 0) ? 18'd261121 : 18'd1;
            end
            @(negedge clk);
            bus_o.in_valid = 1'b0;
            #1;
            vectors++; if (bus_o.out_valid !== 1'b1) begin miscompares++; $display("FAIL ovf_valid_f%0d: got %b want 1", f, bus_o.out_valid); end
            if (f == 0) begin
                vectors++; if (bus_o.out_sum !== exp_big) begin miscompares++; $display("FAIL ovf_sum: got %0d want %0d", bus_o.out_sum, exp_big); end
                vectors++; if (bus_o.out_ovf !== exp_big_ovf) begin miscompares++; $display("FAIL ovf_flag: got %b want %b", bus_o.out_ovf, exp_big_ovf); end
            end else begin
                vectors++; if (bus_o.out_sum !== 20'd8) begin miscompares++; $display("FAIL ovf_next_sum: got %0d want 8", bus_o.out_sum); end
                vectors++; if (bus_o.out_ovf !== 1'b0) begin miscompares++; $display("FAIL ovf_next_flag: got %b want 0", bus_o.out_ovf); end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_len1();
        int unsigned vals [2];
        vals[0] = 3; vals[1] = 9;
        bus_1.out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bus_1.in_valid = 1'b1; bus_1.in_prod = 18'(vals[k]);
            #1;
            vectors++; if (bus_1.in_ready !== 1'b1) begin miscompares++; $display("FAIL len1_in_ready_%0d: got %b want 1", k, bus_1.in_ready); end
            vectors++; if (bus_1.out_valid !== 1'b0) begin miscompares++; $display("FAIL len1_idle_valid_%0d: got %b want 0", k, bus_1.out_valid); end
            @(negedge clk);
            bus_1.in_prod = 18'd9;
            bus_1.in_valid = (k == 0);
            #1;
            vectors++; if (bus_1.out_valid !== 1'b1) begin miscompares++; $display("FAIL len1_valid_%0d: got %b want 1", k, bus_1.out_valid); end
            vectors++; if (bus_1.out_sum !== 32'(vals[k])) begin miscompares++; $display("FAIL len1_sum_%0d: got %0d want %0d", k, bus_1.out_sum, vals[k]); end
            vectors++; if (bus_1.in_ready !== 1'b0) begin miscompares++; $display("FAIL len1_hold_in_ready_%0d: got %b want 0", k, bus_1.in_ready); end
        end
        @(negedge clk);
        bus_1.in_valid = 1'b0;
        #1;
        vectors++; if (bus_1.out_valid !== 1'b0) begin miscompares++; $display("FAIL len1_final_valid: got %b want 0", bus_1.out_valid); end
    endtask

    task automatic test_random();
        int unsigned     q[$];
        bit              pend;
        logic [31:0]     exp_sum;
        logic            exp_ovf;
        logic            exp_rdy;
        bit              acc_b;
        bit              xfer;
        bit              clr;
        int unsigned     prod;
        longint unsigned tot;
        pend = 0; exp_sum = '0; exp_ovf = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            prod = $urandom_range(0, 262143);
            clr  = ($urandom_range(0, 99) < 3);
            bus0.in_valid  = ($urandom_range(0, 9) < 7);
            bus0.in_prod   = 18'(prod);
            bus0.clear     = clr;
            bus0.out_ready = ($urandom_range(0, 9) < 6);
            #1;
            exp_rdy = !pend && !clr;
            vectors++; if (bus0.in_ready !== exp_rdy) begin miscompares++; $display("FAIL rnd_in_ready c%0d: got %b want %b", c, bus0.in_ready, exp_rdy); end
            vectors++; if (bus0.out_valid !== pend) begin miscompares++; $display("FAIL rnd_out_valid c%0d: got %b want %b", c, bus0.out_valid, pend); end
            if (pend) begin
                vectors++; if (bus0.out_sum !== exp_sum) begin miscompares++; $display("FAIL rnd_out_sum c%0d: got %0d want %0d", c, bus0.out_sum, exp_sum); end
                vectors++; if (bus0.out_ovf !== exp_ovf) begin miscompares++; $display("FAIL rnd_out_ovf c%0d: got %b want %b", c, bus0.out_ovf, exp_ovf); end
            end
            acc_b = bus0.in_valid && exp_rdy;
            xfer  = pend && bus0.out_ready;
            @(posedge clk);
            if (xfer) pend = 0;
            else if (!pend && clr) q.delete();
            else if (acc_b) begin
                q.push_back(prod);
                if (q.size() == 8) begin
                    tot = 0;
                    foreach (q[i]) tot += longint'(q[i]);
                    frame_result(tot, 32, exp_sum, exp_ovf);
                    pend = 1;
                    q.delete();
                end
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        bus0.in_valid = 1'b0;  bus0.in_prod = '0;  bus0.clear = 1'b0;  bus0.out_ready = 1'b0;
        bus_o.in_valid = 1'b0; bus_o.in_prod = '0; bus_o.clear = 1'b0; bus_o.out_ready = 1'b0;
        bus_1.in_valid = 1'b0; bus_1.in_prod = '0; bus_1.clear = 1'b0; bus_1.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_clear();
        test_async_reset();
        test_overflow();
        test_len1();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
